// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared constants for the DMEM arbiter slice. Holds the port
//            identifiers that tag read responses and the default data and
//            address widths that the arbiter and its users agree on.
// Contents : PORT_CORE / PORT_DBG - requester ids (pipeline / debug-DMA)
//            DEF_D_WIDTH          - default DMEM word width
//            DEF_A_WIDTH          - default DMEM word-address width
//            port_id_t            - one-bit requester id type
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_CORE   = 1'b0;
    localparam port_id_t PORT_DBG    = 1'b1;

    localparam int       DEF_D_WIDTH = 8;
    localparam int       DEF_A_WIDTH = 8;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one single-port DMEM between the pipeline load/store
//            stage (port 0) and the debug/DMA loader (port 1). One access is
//            issued per cycle. Port 0 normally wins; port 1 is forced through
//            once it has been denied MAX_WAIT consecutive requesting cycles.
//            Read data comes back one cycle after the grant and is steered
//            only to the port that issued the read.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            reqN, weN, addrN, wdataN  - requester N access (N = 0, 1)
//            gntN                      - request accepted this cycle (comb.)
//            rvalidN, rdataN           - read response for requester N
//            mem_cs, mem_wen_ren,
//            mem_addr, mem_wdata       - DMEM command (1 = write, 0 = read)
//            mem_rdata                 - DMEM read data, one cycle latency
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int D_WIDTH  = DEF_D_WIDTH,
    parameter int A_WIDTH  = DEF_A_WIDTH,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               we0,
    input  logic [A_WIDTH-1:0] addr0,
    input  logic [D_WIDTH-1:0] wdata0,
    input  logic               req1,
    input  logic               we1,
    input  logic [A_WIDTH-1:0] addr1,
    input  logic [D_WIDTH-1:0] wdata1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic [D_WIDTH-1:0] rdata0,
    output logic               rvalid1,
    output logic [D_WIDTH-1:0] rdata1,
    output logic               mem_cs,
    output logic               mem_wen_ren,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       r_rd_pending;
    port_id_t   r_rd_owner;

    logic       w_force1;
    logic       w_gnt0;
    logic       w_gnt1;

    // Port 1 has lost c_MAX_WAIT requesting cycles in a row: it now
    // overrides the normal port-0 priority for exactly one grant.
    assign w_force1 = (r_wait_cnt == c_MAX_WAIT);

    // Grants are gated by rst so nothing reaches the DMEM during reset,
    // including the cycle in which reset is first raised.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (req1 && w_force1) begin
                w_gnt1 = 1'b1;
            end else if (req0) begin
                w_gnt0 = 1'b1;
            end else if (req1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    // Command mux: idle cycles drive an all-zero command.
    always_comb begin
        mem_cs      = w_gnt0 | w_gnt1;
        mem_wen_ren = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (w_gnt1) begin
            mem_wen_ren = we1;
            mem_addr    = addr1;
            mem_wdata   = wdata1;
        end else if (w_gnt0) begin
            mem_wen_ren = we0;
            mem_addr    = addr0;
            mem_wdata   = wdata0;
        end
    end

    // Starvation counter plus one-deep read-response tag. A new tag is
    // loaded every cycle, so back-to-back reads from either port each get
    // their own response slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt   <= 4'd0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= PORT_CORE;
        end else begin
            if (w_gnt1 || !req1) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt != c_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            r_rd_pending <= (w_gnt0 && !we0) || (w_gnt1 && !we1);
            r_rd_owner   <= w_gnt1 ? PORT_DBG : PORT_CORE;
        end
    end

    // A response already in flight when reset rises is suppressed in that
    // same cycle rather than leaking out before the register clears.
    assign rvalid0 = r_rd_pending && !rst && (r_rd_owner == PORT_CORE);
    assign rvalid1 = r_rd_pending && !rst && (r_rd_owner == PORT_DBG);
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A directed cycle table
//            covers reset, write/read, contention, interleaved reads, a
//            port-1-only write and reset during a read; a random phase checks
//            every output against a behavioural model of the arbitration
//            rules and a shadow copy of memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic       clk;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       mem_cs, mem_wen_ren;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(
        .D_WIDTH  (8),
        .A_WIDTH  (8),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rvalid0     (rvalid0),
        .rdata0      (rdata0),
        .rvalid1     (rvalid1),
        .rdata1      (rdata1),
        .mem_cs      (mem_cs),
        .mem_wen_ren (mem_wen_ren),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM seen by the arbiter.
    logic [7:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        mem_rdata = 8'd0;
    end
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wen_ren) mem[mem_addr] <= mem_wdata;
            else             mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        int rst;
        int r0, w0, a0, d0;
        int r1, w1, a1, d1;
        int g0, g1, cs, wen, ma;
        int rv0, rd0, rv1, rd1;
    } vec_t;

    vec_t vq[$];

    task automatic v(input int rst_i,
                     input int r0, input int w0, input int a0, input int d0,
                     input int r1, input int w1, input int a1, input int d1,
                     input int g0, input int g1, input int cs, input int wen,
                     input int ma, input int rv0, input int rd0,
                     input int rv1, input int rd1);
        vec_t t;
        t.rst = rst_i;
        t.r0 = r0;  t.w0 = w0;  t.a0 = a0;  t.d0 = d0;
        t.r1 = r1;  t.w1 = w1;  t.a1 = a1;  t.d1 = d1;
        t.g0 = g0;  t.g1 = g1;  t.cs = cs;  t.wen = wen; t.ma = ma;
        t.rv0 = rv0; t.rd0 = rd0; t.rv1 = rv1; t.rd1 = rd1;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic drive(input int rst_i,
                         input int r0, input int w0, input int a0, input int d0,
                         input int r1, input int w1, input int a1, input int d1);
        rst    = 1'(rst_i);
        req0   = 1'(r0);  we0 = 1'(w0);  addr0 = 8'(a0);  wdata0 = 8'(d0);
        req1   = 1'(r1);  we1 = 1'(w1);  addr1 = 8'(a1);  wdata1 = 8'(d1);
    endtask

    // Reference model state for the random phase.
    int       denied;
    bit       pend;
    int       pend_own;
    int       pend_data;
    int       shadow [0:255];

    initial begin
        string tag;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //  rst r0 w0 a0 d0  r1 w1 a1 d1   g0 g1 cs wen ma  rv0 rd0 rv1 rd1
        // reset held two cycles with both ports requesting
        v(1, 1,0,3,0,   1,0,5,0,    0,0,0,0,0,  0,0,  0,0);
        v(1, 1,0,3,0,   1,0,5,0,    0,0,0,0,0,  0,0,  0,0);
        // port 0 write then read of address 3
        v(0, 1,1,3,30,  0,0,0,0,    1,0,1,1,3,  0,0,  0,0);
        v(0, 1,0,3,0,   0,0,0,0,    1,0,1,0,3,  0,0,  0,0);
        v(0, 0,0,0,0,   0,0,0,0,    0,0,0,0,0,  1,30, 0,0);
        // interleaved reads: port 0 at 4, port 1 at 5
        v(0, 1,1,4,40,  0,0,0,0,    1,0,1,1,4,  0,0,  0,0);
        v(0, 1,1,5,50,  0,0,0,0,    1,0,1,1,5,  0,0,  0,0);
        v(0, 1,0,4,0,   0,0,0,0,    1,0,1,0,4,  0,0,  0,0);
        v(0, 0,0,0,0,   1,0,5,0,    0,1,1,0,5,  1,40, 0,0);
        v(0, 0,0,0,0,   0,0,0,0,    0,0,0,0,0,  0,0,  1,50);
        // port 1 alone writes 70 to 7, port 0 reads it back
        v(0, 0,0,0,0,   1,1,7,70,   0,1,1,1,7,  0,0,  0,0);
        v(0, 1,0,7,0,   0,0,0,0,    1,0,1,0,7,  0,0,  0,0);
        v(0, 0,0,0,0,   0,0,0,0,    0,0,0,0,0,  1,70, 0,0);
        // contention: four port-0 wins, forced port-1 win, port 0 resumes
        v(0, 1,0,3,0,   1,0,4,0,    1,0,1,0,3,  0,0,  0,0);
        v(0, 1,0,3,0,   1,0,4,0,    1,0,1,0,3,  1,30, 0,0);
        v(0, 1,0,3,0,   1,0,4,0,    1,0,1,0,3,  1,30, 0,0);
        v(0, 1,0,3,0,   1,0,4,0,    1,0,1,0,3,  1,30, 0,0);
        v(0, 1,0,3,0,   1,0,4,0,    0,1,1,0,4,  1,30, 0,0);
        v(0, 1,0,3,0,   0,0,0,0,    1,0,1,0,3,  0,0,  1,40);
        v(0, 0,0,0,0,   0,0,0,0,    0,0,0,0,0,  1,30, 0,0);
        // reset one cycle after a port-0 read grant
        v(0, 1,0,4,0,   0,0,0,0,    1,0,1,0,4,  0,0,  0,0);
        v(1, 1,0,4,0,   1,0,7,0,    0,0,0,0,0,  0,0,  0,0);
        // wait counter restarts from zero: again four port-0 wins first
        v(0, 1,0,5,0,   1,0,7,0,    1,0,1,0,5,  0,0,  0,0);
        v(0, 1,0,5,0,   1,0,7,0,    1,0,1,0,5,  1,50, 0,0);
        v(0, 1,0,5,0,   1,0,7,0,    1,0,1,0,5,  1,50, 0,0);
        v(0, 1,0,5,0,   1,0,7,0,    1,0,1,0,5,  1,50, 0,0);
        v(0, 1,0,5,0,   1,0,7,0,    0,1,1,0,7,  1,50, 0,0);
        v(0, 0,0,0,0,   0,0,0,0,    0,0,0,0,0,  0,0,  1,70);

        @(posedge clk);
        #1;
        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].r0, vq[i].w0, vq[i].a0, vq[i].d0,
                  vq[i].r1, vq[i].w1, vq[i].a1, vq[i].d1);
            @(negedge clk);
            tag = $sformatf("vec%0d", i);
            chk({tag, " gnt0"},        int'(gnt0),        vq[i].g0);
            chk({tag, " gnt1"},        int'(gnt1),        vq[i].g1);
            chk({tag, " mem_cs"},      int'(mem_cs),      vq[i].cs);
            chk({tag, " mem_wen_ren"}, int'(mem_wen_ren), vq[i].wen);
            chk({tag, " mem_addr"},    int'(mem_addr),    vq[i].ma);
            chk({tag, " rvalid0"},     int'(rvalid0),     vq[i].rv0);
            chk({tag, " rdata0"},      int'(rdata0),      vq[i].rd0);
            chk({tag, " rvalid1"},     int'(rvalid1),     vq[i].rv1);
            chk({tag, " rdata1"},      int'(rdata1),      vq[i].rd1);
            @(posedge clk);
            #1;
        end

        // Random phase on addresses 16..31, untouched by the directed table.
        for (int a = 0; a < 256; a++) shadow[a] = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        denied   = 0;
        pend     = 1'b0;
        pend_own = 0;
        pend_data = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            int r_rst, r0, w0, a0, d0, r1, w1, a1, d1;
            int e_g0, e_g1, e_wen, e_ma, e_wd, e_rv0, e_rv1;
            bit e_rd_issue;
            r_rst = ($urandom_range(0, 39) == 0) ? 1 : 0;
            r0 = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r1 = ($urandom_range(0, 3) != 0) ? 1 : 0;
            w0 = int'($urandom_range(0, 1));
            w1 = int'($urandom_range(0, 1));
            a0 = int'($urandom_range(16, 31));
            a1 = int'($urandom_range(16, 31));
            d0 = int'($urandom_range(0, 255));
            d1 = int'($urandom_range(0, 255));
            drive(r_rst, r0, w0, a0, d0, r1, w1, a1, d1);
            @(negedge clk);

            e_g0 = 0;
            e_g1 = 0;
            if (r_rst == 0) begin
                if (r1 == 1 && denied >= MAX_WAIT) e_g1 = 1;
                else if (r0 == 1)                  e_g0 = 1;
                else if (r1 == 1)                  e_g1 = 1;
            end
            e_wen = e_g1 ? w1 : (e_g0 ? w0 : 0);
            e_ma  = e_g1 ? a1 : (e_g0 ? a0 : 0);
            e_wd  = e_g1 ? d1 : (e_g0 ? d0 : 0);
            e_rv0 = (r_rst == 0 && pend && pend_own == 0) ? 1 : 0;
            e_rv1 = (r_rst == 0 && pend && pend_own == 1) ? 1 : 0;

            chk("rnd gnt0",        int'(gnt0),        e_g0);
            chk("rnd gnt1",        int'(gnt1),        e_g1);
            chk("rnd mem_cs",      int'(mem_cs),      e_g0 | e_g1);
            chk("rnd mem_wen_ren", int'(mem_wen_ren), e_wen);
            chk("rnd mem_addr",    int'(mem_addr),    e_ma);
            chk("rnd mem_wdata",   int'(mem_wdata),   e_wd);
            chk("rnd rvalid0",     int'(rvalid0),     e_rv0);
            chk("rnd rvalid1",     int'(rvalid1),     e_rv1);
            chk("rnd rdata0",      int'(rdata0),      e_rv0 ? pend_data : 0);
            chk("rnd rdata1",      int'(rdata1),      e_rv1 ? pend_data : 0);

            // Advance the model across the coming clock edge.
            if (r_rst == 1) begin
                denied = 0;
                pend   = 1'b0;
            end else begin
                if (e_g1 == 1 || r1 == 0)   denied = 0;
                else if (denied < MAX_WAIT) denied = denied + 1;
                e_rd_issue = ((e_g0 | e_g1) == 1) && (e_wen == 0);
                pend     = e_rd_issue;
                pend_own = e_g1;
                if (e_rd_issue) pend_data = shadow[e_ma];
                if ((e_g0 | e_g1) == 1 && e_wen == 1) shadow[e_ma] = e_wd;
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
